// File: rtl/dispatch_fu_alloc.sv
// -----------------------------------------------------------------------------
// dispatch_fu_alloc
//   Dispatch-side functional-unit allocator with register status tables.
//   It takes one decoded instruction per cycle. The instruction stalls when its
//   functional unit is busy (structural hazard) or when its destination already
//   has a pending writer (WAW hazard). An accepted instruction produces a
//   registered one-hot FUST row write. The row carries the producer tag of each
//   source operand. fu_done pulses retire busy units and pending tags, and
//   flush clears all tracking state.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   flush, freeze        pipeline flush (clears state) / freeze (blocks accept)
//   inst_valid           a decoded instruction is presented
//   fu_sel               target FU: 0 ALU, 1 LDST, 2 BRANCH, 3 MLS, 4 GEMM
//   rd, rd_mat, rd_we    destination index, matrix flag, write enable
//   rs1/rs2, rs*_mat     source indices and matrix flags
//   fu_done              per-FU completion pulses
//   ready                instruction accepted this cycle (combinational)
//   fust_en              one-hot FUST row write enable (registered pulse)
//   row_rd/rs1/rs2       captured operand indices
//   row_t1/t2            source producer tags (0 = ready, k = FU k-1 pending)
//   fu_busy              current busy vector
// -----------------------------------------------------------------------------
module dispatch_fu_alloc #(
  parameter int NUM_SREGS = 32,
  parameter int NUM_MREGS = 16,
  parameter int NUM_FU    = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              freeze,
  input  logic              inst_valid,
  input  logic [2:0]        fu_sel,
  input  logic [4:0]        rd,
  input  logic              rd_mat,
  input  logic              rd_we,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic              rs1_mat,
  input  logic              rs2_mat,
  input  logic [NUM_FU-1:0] fu_done,
  output logic              ready,
  output logic [NUM_FU-1:0] fust_en,
  output logic [4:0]        row_rd,
  output logic [4:0]        row_rs1,
  output logic [4:0]        row_rs2,
  output logic [2:0]        row_t1,
  output logic [2:0]        row_t2,
  output logic [NUM_FU-1:0] fu_busy
);

  localparam int SW = $clog2(NUM_SREGS);
  localparam int MW = $clog2(NUM_MREGS);

  // Producer tag per register: 0 = no pending writer, k = FU k-1 will write it.
  logic [2:0] srst [NUM_SREGS];
  logic [2:0] mrst [NUM_MREGS];

  // A tag whose producer completes this cycle already counts as ready.
  function automatic logic [2:0] tag_eff(input logic [2:0] t,
                                         input logic [NUM_FU-1:0] done);
    tag_eff = t;
    for (int k = 0; k < NUM_FU; k++)
      if (done[k] && t == 3'(k + 1)) tag_eff = 3'd0;
  endfunction

  logic [NUM_FU-1:0] fu_onehot;
  logic [NUM_FU-1:0] busy_eff;
  logic [2:0]        rs1_tag, rs2_tag, rd_tag;
  logic              rd_tracked;
  logic              struct_haz, waw_haz;
  logic [2:0]        new_tag;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fu_onehot = '0;
    rs1_tag   = 3'd0;
    rs2_tag   = 3'd0;
    rd_tag    = 3'd0;

    for (int k = 0; k < NUM_FU; k++) fu_onehot[k] = (fu_sel == 3'(k));
    busy_eff = fu_busy & ~fu_done;

    // Scalar x0 is never tracked, so it always reads as ready.
    if (rs1_mat)         rs1_tag = mrst[rs1[MW-1:0]];
    else if (rs1 != '0)  rs1_tag = srst[rs1[SW-1:0]];
    if (rs2_mat)         rs2_tag = mrst[rs2[MW-1:0]];
    else if (rs2 != '0)  rs2_tag = srst[rs2[SW-1:0]];
    if (rd_mat)          rd_tag  = mrst[rd[MW-1:0]];
    else if (rd != '0)   rd_tag  = srst[rd[SW-1:0]];

    rs1_tag = tag_eff(rs1_tag, fu_done);
    rs2_tag = tag_eff(rs2_tag, fu_done);
    rd_tag  = tag_eff(rd_tag, fu_done);

    rd_tracked = rd_we && (rd_mat || rd != '0);
    // An out-of-range fu_sel selects no unit and is treated as always busy.
    struct_haz = (fu_onehot == '0) || ((fu_onehot & busy_eff) != '0);
    waw_haz    = rd_tracked && (rd_tag != 3'd0);
    ready      = inst_valid && !struct_haz && !waw_haz && !freeze && !flush;
    new_tag    = fu_sel + 3'd1;
  end

  // Busy vector and register status tables. A same-cycle accept overrides the
  // retirement of a completing unit or tag, because the set is applied last.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fu_busy <= '0;
      // NOTE: the status tables are reset like plain flops, not left as RAM,
      // because a stale nonzero tag would stall or mis-tag after reset.
      for (int i = 0; i < NUM_SREGS; i++) srst[i] <= 3'd0;
      for (int i = 0; i < NUM_MREGS; i++) mrst[i] <= 3'd0;
    end else if (flush) begin
      fu_busy <= '0;
      for (int i = 0; i < NUM_SREGS; i++) srst[i] <= 3'd0;
      for (int i = 0; i < NUM_MREGS; i++) mrst[i] <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the pre-edge value regardless of order.
      fu_busy <= busy_eff | (ready ? fu_onehot : '0);
      for (int i = 0; i < NUM_SREGS; i++) begin
        if (ready && rd_tracked && !rd_mat && rd[SW-1:0] == SW'(i))
          srst[i] <= new_tag;
        else
          srst[i] <= tag_eff(srst[i], fu_done);
      end
      for (int i = 0; i < NUM_MREGS; i++) begin
        if (ready && rd_tracked && rd_mat && rd[MW-1:0] == MW'(i))
          mrst[i] <= new_tag;
        else
          mrst[i] <= tag_eff(mrst[i], fu_done);
      end
    end
  end

  // FUST row write: single-cycle enable pulse, fields hold between accepts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fust_en <= '0;
      row_rd  <= '0;
      row_rs1 <= '0;
      row_rs2 <= '0;
      row_t1  <= '0;
      row_t2  <= '0;
    end else begin
      fust_en <= ready ? fu_onehot : '0;
      if (ready) begin
        row_rd  <= rd;
        row_rs1 <= rs1;
        row_rs2 <= rs2;
        row_t1  <= rs1_tag;
        row_t2  <= rs2_tag;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_fu_alloc.sv
// -----------------------------------------------------------------------------
// tb_dispatch_fu_alloc
//   Directed scenarios followed by randomized traffic. All of it is compared
//   against a reference model of the allocator that uses integer arrays.
// -----------------------------------------------------------------------------
module tb_dispatch_fu_alloc;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       flush, freeze, inst_valid;
  logic [2:0] fu_sel;
  logic [4:0] rd, rs1, rs2;
  logic       rd_mat, rd_we, rs1_mat, rs2_mat;
  logic [4:0] fu_done;
  logic       ready;
  logic [4:0] fust_en, fu_busy;
  logic [4:0] row_rd, row_rs1, row_rs2;
  logic [2:0] row_t1, row_t2;

  dispatch_fu_alloc dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .freeze(freeze),
    .inst_valid(inst_valid), .fu_sel(fu_sel), .rd(rd), .rd_mat(rd_mat),
    .rd_we(rd_we), .rs1(rs1), .rs2(rs2), .rs1_mat(rs1_mat), .rs2_mat(rs2_mat),
    .fu_done(fu_done), .ready(ready), .fust_en(fust_en), .row_rd(row_rd),
    .row_rs1(row_rs1), .row_rs2(row_rs2), .row_t1(row_t1), .row_t2(row_t2),
    .fu_busy(fu_busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_busy [5];
  int m_s    [32];
  int m_m    [16];
  int e_fust, e_rd, e_rs1, e_rs2, e_t1, e_t2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++)  m_busy[k] = 0;
    for (int i = 0; i < 32; i++) m_s[i] = 0;
    for (int i = 0; i < 16; i++) m_m[i] = 0;
    e_fust = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0; e_t1 = 0; e_t2 = 0;
  endtask

  // A tag whose producer completes this cycle counts as no pending writer.
  function automatic int teff(input int t);
    if (t >= 1 && t <= 5 && fu_done[t-1]) return 0;
    return t;
  endfunction

  function automatic int src_tag(input int idx, input bit mat);
    if (mat)      return teff(m_m[idx % 16]);
    if (idx == 0) return 0;
    return teff(m_s[idx]);
  endfunction

  function automatic bit m_ready();
    if (!inst_valid || freeze || flush) return 0;
    if (fu_sel > 4) return 0;
    if (m_busy[fu_sel] != 0 && !fu_done[fu_sel]) return 0;
    if (rd_we && (rd_mat || rd != 0) && src_tag(int'(rd), rd_mat) != 0) return 0;
    return 1;
  endfunction

  task automatic set(input bit iv, input int sel, input int d, input bit dm,
                     input bit we, input int s1, input bit s1m, input int s2,
                     input bit s2m, input logic [4:0] done,
                     input bit fl = 0, input bit fr = 0);
    inst_valid = iv; fu_sel = 3'(sel); rd = 5'(d); rd_mat = dm; rd_we = we;
    rs1 = 5'(s1); rs1_mat = s1m; rs2 = 5'(s2); rs2_mat = s2m;
    fu_done = done; flush = fl; freeze = fr;
  endtask

  task automatic idle(input logic [4:0] done);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, done);
  endtask

  task automatic check_outputs();
    logic [4:0] eb;
    for (int k = 0; k < 5; k++) eb[k] = (m_busy[k] != 0);
    check("fust_en", 32'(fust_en), 32'(e_fust));
    check("row_rd",  32'(row_rd),  32'(e_rd));
    check("row_rs1", 32'(row_rs1), 32'(e_rs1));
    check("row_rs2", 32'(row_rs2), 32'(e_rs2));
    check("row_t1",  32'(row_t1),  32'(e_t1));
    check("row_t2",  32'(row_t2),  32'(e_t2));
    check("fu_busy", 32'(fu_busy), 32'(eb));
    for (int i = 0; i < 32; i++) check($sformatf("srst%0d", i), 32'(dut.srst[i]), 32'(m_s[i]));
    for (int i = 0; i < 16; i++) check($sformatf("mrst%0d", i), 32'(dut.mrst[i]), 32'(m_m[i]));
  endtask

  // Check ready against the model, advance the model by one clock, then check
  // the registered outputs one time unit after the edge.
  task automatic step();
    bit acc;
    int t1, t2;
    #1;
    acc = m_ready();
    check("ready", 32'(ready), 32'(acc));
    t1 = src_tag(int'(rs1), rs1_mat);
    t2 = src_tag(int'(rs2), rs2_mat);
    if (flush) begin
      for (int k = 0; k < 5; k++)  m_busy[k] = 0;
      for (int i = 0; i < 32; i++) m_s[i] = 0;
      for (int i = 0; i < 16; i++) m_m[i] = 0;
    end else begin
      for (int k = 0; k < 5; k++)  if (fu_done[k]) m_busy[k] = 0;
      for (int i = 0; i < 32; i++) m_s[i] = teff(m_s[i]);
      for (int i = 0; i < 16; i++) m_m[i] = teff(m_m[i]);
      if (acc) begin
        m_busy[fu_sel] = 1;
        if (rd_we && rd_mat)           m_m[rd % 16] = fu_sel + 1;
        else if (rd_we && rd != 0)     m_s[rd] = fu_sel + 1;
      end
    end
    e_fust = acc ? (1 << fu_sel) : 0;
    if (acc) begin
      e_rd = rd; e_rs1 = rs1; e_rs2 = rs2; e_t1 = t1; e_t2 = t2;
    end
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  initial begin
    nRST = 1'b0;
    idle(5'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check_outputs();
    nRST = 1'b1;

    // ALU add rd=x5 accepted; srst[5] becomes 1
    set(1, 0, 5, 0, 1, 0, 0, 0, 0, 5'b0); step();
    check("alu_fust", 32'(fust_en), 32'b00001);
    check("alu_srst5", 32'(dut.srst[5]), 32'd1);
    // LDST rd=x6 reads x5 -> t1 = 1
    set(1, 1, 6, 0, 1, 5, 0, 0, 0, 5'b0); step();
    check("ldst_t1", 32'(row_t1), 32'd1);
    // Second ALU op while ALU busy: no accept
    set(1, 0, 7, 0, 1, 0, 0, 0, 0, 5'b0); step();
    check("alu_busy_nopulse", 32'(fust_en), 32'd0);
    // WAW on x5 from the free BRANCH unit stalls
    set(1, 2, 5, 0, 1, 0, 0, 0, 0, 5'b0); step();
    check("waw_stall", 32'(fust_en), 32'd0);
    // ALU rd=x5 while the ALU completes: accepted, set wins
    set(1, 0, 5, 0, 1, 0, 0, 0, 0, 5'b00001); step();
    check("bypass_fust", 32'(fust_en), 32'b00001);
    check("setwins_srst5", 32'(dut.srst[5]), 32'd1);
    idle(5'b11111); step();

    // GEMM rd=m3, then MLS reads m3 -> t1 = 5
    set(1, 4, 3, 1, 1, 0, 0, 0, 0, 5'b0); step();
    set(1, 3, 0, 0, 0, 3, 1, 0, 0, 5'b0); step();
    check("mls_t1", 32'(row_t1), 32'd5);
    idle(5'b10000); step();
    check("gemm_mrst3", 32'(dut.mrst[3]), 32'd0);
    check("gemm_busy", 32'(fu_busy[4]), 32'd0);
    idle(5'b11111); step();

    // rd = x0 twice: never a WAW stall
    set(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b0); step();
    idle(5'b00001); step();
    set(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b0); step();
    check("x0_fust", 32'(fust_en), 32'b00001);
    check("x0_srst0", 32'(dut.srst[0]), 32'd0);
    idle(5'b11111); step();

    // Back-to-back ALU and LDST, then flush with a valid instruction
    set(1, 0, 8, 0, 1, 0, 0, 0, 0, 5'b0); step();
    set(1, 1, 9, 1, 1, 8, 0, 0, 0, 5'b0); step();
    check("b2b_fust", 32'(fust_en), 32'b00010);
    set(1, 2, 10, 0, 1, 9, 1, 8, 0, 5'b0, 1); step();
    check("flush_busy", 32'(fu_busy), 32'd0);
    check("flush_fust", 32'(fust_en), 32'd0);
    // Freeze with LDST completing: busy clears, no accept
    set(1, 1, 11, 0, 1, 0, 0, 0, 0, 5'b0); step();
    set(1, 2, 12, 0, 1, 0, 0, 0, 0, 5'b00010, 0, 1); step();
    check("freeze_busy1", 32'(fu_busy[1]), 32'd0);
    check("freeze_fust", 32'(fust_en), 32'd0);

    // Asynchronous reset in the middle of a cycle
    set(1, 4, 20, 0, 1, 0, 0, 0, 0, 5'b0); step();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check("areset_busy", 32'(fu_busy), 32'd0);
    check("areset_fust", 32'(fust_en), 32'd0);
    check("areset_srst20", 32'(dut.srst[20]), 32'd0);
    idle(5'b0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    set(1, 4, 20, 0, 1, 0, 0, 0, 0, 5'b0); step();
    check("post_reset_fust", 32'(fust_en), 32'b10000);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      set($urandom_range(0, 9) < 7, $urandom_range(0, 5),
          $urandom_range(0, 31), $urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
          $urandom_range(0, 31), $urandom_range(0, 9) < 3,
          $urandom_range(0, 31), $urandom_range(0, 9) < 3,
          5'($urandom) & 5'($urandom),
          $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
